// File: rtl/uart_pkt_tx.sv
// Packet UART transmitter: sends NUM_BYTES of payload as back-to-back 8N1 frames,
// most-significant byte first and LSB first within each byte; busy while in flight.
module uart_pkt_tx #(
  parameter int NUM_BYTES    = 36,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   send_data,
  input  logic [NUM_BYTES*8-1:0] tx_data,
  output logic                   serial_out,
  output logic                   busy,
  output logic                   done
);

  localparam int PW = NUM_BYTES * 8;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST  = BW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [BW-1:0]   byte_cnt;
  logic [PW-1:0]   pkt_sr;
  logic [7:0]      byte_sr;
  logic            tick;
  logic            last_byte;
  logic            accept;

  assign tick      = (timer == TIMER_LAST);
  assign last_byte = (byte_cnt == BYTE_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    serial_out = 1'b1;
    busy       = 1'b1;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (send_data) begin
          accept    = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        serial_out = 1'b0;
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        serial_out = byte_sr[0];
        if (tick && bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: begin
        if (tick) begin
          if (last_byte) begin
            state_nxt = IDLE;
            done      = ~rst;  // a reset in the final cycle must not report completion
          end else begin
            state_nxt = START;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The next byte is pulled from the top of the packet register as its start bit ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      pkt_sr   <= '0;
      byte_sr  <= '0;
    end else begin
      if (state == IDLE) begin
        timer <= '0;
      end else begin
        timer <= tick ? '0 : timer + 1'b1;
      end
      case (state)
        IDLE: begin
          bit_idx  <= '0;
          byte_cnt <= '0;
          if (accept) pkt_sr <= tx_data;
        end
        START: begin
          if (tick) begin
            byte_sr <= pkt_sr[PW-1 -: 8];
            pkt_sr  <= pkt_sr << 8;
          end
        end
        DATA: begin
          if (tick) begin
            byte_sr <= byte_sr >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (tick && !last_byte) byte_cnt <= byte_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Bench for uart_pkt_tx: cycle table for a 1-byte packet, plus loopback receivers
// feeding a byte scoreboard for the default, reset and back-to-back cases.
module tb_uart_pkt_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: 1 byte, 4 clocks/bit
  logic         rst_a = 1'b1, send_a = 1'b0;
  logic [7:0]   tx_a = 8'hA5;
  logic         ser_a, busy_a, done_a;
  // instance B: defaults
  logic         rst_b = 1'b1, send_b = 1'b0;
  logic [287:0] tx_b = '0;
  logic         ser_b, busy_b, done_b;
  // instance C: 2 bytes, 4 clocks/bit
  logic         rst_c = 1'b1, send_c = 1'b0;
  logic [15:0]  tx_c = '0;
  logic         ser_c, busy_c, done_c;

  uart_pkt_tx #(.NUM_BYTES(1), .CLKS_PER_BIT(4)) u_a (
    .clk(clk), .rst(rst_a), .send_data(send_a), .tx_data(tx_a),
    .serial_out(ser_a), .busy(busy_a), .done(done_a));
  uart_pkt_tx u_b (
    .clk(clk), .rst(rst_b), .send_data(send_b), .tx_data(tx_b),
    .serial_out(ser_b), .busy(busy_b), .done(done_b));
  uart_pkt_tx #(.NUM_BYTES(2), .CLKS_PER_BIT(4)) u_c (
    .clk(clk), .rst(rst_c), .send_data(send_c), .tx_data(tx_c),
    .serial_out(ser_c), .busy(busy_c), .done(done_c));

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] exp_c[$];
  logic [7:0] bytes_b [36];

  typedef struct {
    logic rst;
    logic send;
    logic exp_line;
    logic exp_busy;
    logic exp_done;
  } vec_t;
  vec_t vecs [46];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic line_of(input int id);
    case (id)
      0:       return ser_a;
      1:       return ser_b;
      default: return ser_c;
    endcase
  endfunction

  function automatic logic busy_of(input int id);
    case (id)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic sb_check(input int id, input logic [7:0] d);
    logic [7:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    case (id)
      0: if (exp_a.size() > 0) begin have = 1'b1; e = exp_a.pop_front(); end
      1: if (exp_b.size() > 0) begin have = 1'b1; e = exp_b.pop_front(); end
      default: if (exp_c.size() > 0) begin have = 1'b1; e = exp_c.pop_front(); end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL rx%0d_extra: got byte %02h expected none", id, d);
    end else begin
      check($sformatf("rx%0d_byte", id), {24'd0, d}, {24'd0, e});
    end
  endtask

  // Loopback receiver: samples mid-bit, drops a frame if the transmitter stops being busy.
  task automatic rx_run(input int id, input int cpb);
    logic [7:0] d;
    logic       stop_bit;
    bit         ok;
    forever begin
      @(negedge clk);
      if (line_of(id) === 1'b0 && busy_of(id) === 1'b1) begin
        ok = 1'b1;
        d = '0;
        stop_bit = 1'b0;
        for (int t = 1; t <= cpb * 9 + cpb / 2; t++) begin
          @(negedge clk);
          if (busy_of(id) !== 1'b1) begin
            ok = 1'b0;
            break;
          end
          if (t >= cpb && t < 9 * cpb && (t % cpb) == cpb / 2) d[3'(t / cpb - 1)] = line_of(id);
          if (t == 9 * cpb + cpb / 2) stop_bit = line_of(id);
        end
        if (ok) begin
          check($sformatf("rx%0d_stop", id), {31'd0, stop_bit}, 32'd1);
          sb_check(id, d);
        end
      end
    end
  endtask

  initial rx_run(0, 4);
  initial rx_run(1, 16);
  initial rx_run(2, 4);

  task automatic mk_pkt_b(input int mode);
    for (int k = 0; k < 36; k++) begin
      if (mode == 0) begin
        if (k == 0)       bytes_b[k] = 8'hDA;
        else if (k == 1)  bytes_b[k] = 8'h83;
        else if (k == 35) bytes_b[k] = 8'h00;
        else              bytes_b[k] = 8'(k * 37 + 11);
      end else if (mode == 1) begin
        bytes_b[k] = 8'(k * 53 + 7);
      end else begin
        bytes_b[k] = 8'($urandom_range(0, 255));
      end
      tx_b[8*(36-k)-1 -: 8] = bytes_b[k];
    end
  endtask

  initial begin
    logic [9:0] frame;
    int nbusy, ndone, d1, d2;

    // cycle table for instance A: rst+send together, then a single send pulse
    frame = {1'b1, tx_a, 1'b0};
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 1; c <= 40; c++) vecs[2+c] = '{1'b0, 1'b0, frame[(c-1)/4], 1'b1, (c == 40)};
    for (int i = 43; i < 46; i++) vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_b_line", {31'd0, ser_b}, 32'd1);
    check("rst_b_busy", {31'd0, busy_b}, 32'd0);
    check("rst_b_done", {31'd0, done_b}, 32'd0);
    check("rst_c_line", {31'd0, ser_c}, 32'd1);
    check("rst_c_busy", {31'd0, busy_c}, 32'd0);
    rst_b = 1'b0;
    rst_c = 1'b0;

    for (int i = 0; i < 46; i++) begin
      @(negedge clk);
      check($sformatf("a_line[%0d]", i), {31'd0, ser_a}, {31'd0, vecs[i].exp_line});
      check($sformatf("a_busy[%0d]", i), {31'd0, busy_a}, {31'd0, vecs[i].exp_busy});
      check($sformatf("a_done[%0d]", i), {31'd0, done_a}, {31'd0, vecs[i].exp_done});
      rst_a  = vecs[i].rst;
      send_a = vecs[i].send;
      if (vecs[i].send && !vecs[i].rst) exp_a.push_back(tx_a);
    end

    // B: full default packet, with a re-pulse and changed data 100 cycles in
    mk_pkt_b(0);
    @(negedge clk);
    send_b = 1'b1;
    for (int k = 0; k < 36; k++) exp_b.push_back(bytes_b[k]);
    nbusy = 0;
    ndone = 0;
    for (int c = 1; c <= 5800; c++) begin
      @(negedge clk);
      if (c == 1) check("b_first_start", {31'd0, ser_b}, 32'd0);
      if (busy_b) nbusy++;
      if (done_b) ndone++;
      send_b = (c == 100);
      if (c == 100) tx_b = ~tx_b;
    end
    check("b_busy_cycles", nbusy, 5760);
    check("b_done_count", ndone, 1);
    nbusy = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy_b) nbusy++;
    end
    check("b_no_extra_pkt", nbusy, 0);

    // B: reset during the data bits of byte 3
    mk_pkt_b(1);
    @(negedge clk);
    send_b = 1'b1;
    for (int k = 0; k < 3; k++) exp_b.push_back(bytes_b[k]);
    ndone = 0;
    for (int c = 1; c <= 620; c++) begin
      @(negedge clk);
      send_b = 1'b0;
      if (done_b) ndone++;
      if (c == 550) begin
        check("b_busy_pre_rst", {31'd0, busy_b}, 32'd1);
        rst_b = 1'b1;
      end
      if (c == 551) begin
        check("b_rst_line", {31'd0, ser_b}, 32'd1);
        check("b_rst_busy", {31'd0, busy_b}, 32'd0);
        check("b_rst_done", {31'd0, done_b}, 32'd0);
        rst_b = 1'b0;
      end
    end
    check("b_rst_no_done", ndone, 0);

    // B: fresh packet after reset release
    mk_pkt_b(2);
    @(negedge clk);
    send_b = 1'b1;
    for (int k = 0; k < 36; k++) exp_b.push_back(bytes_b[k]);
    nbusy = 0;
    ndone = 0;
    for (int c = 1; c <= 5800; c++) begin
      @(negedge clk);
      send_b = 1'b0;
      if (busy_b) nbusy++;
      if (done_b) ndone++;
    end
    check("b2_busy_cycles", nbusy, 5760);
    check("b2_done_count", ndone, 1);

    // C: send held high across two packets; data changes before the second accept
    @(negedge clk);
    tx_c = 16'h5E21;
    send_c = 1'b1;
    exp_c.push_back(8'h5E);
    exp_c.push_back(8'h21);
    d1 = -1;
    d2 = -1;
    ndone = 0;
    for (int c = 1; c <= 240; c++) begin
      @(negedge clk);
      if (c == 10) begin
        tx_c = 16'h96F0;
        exp_c.push_back(8'h96);
        exp_c.push_back(8'hF0);
      end
      if (c == 120) send_c = 1'b0;
      if (done_c) begin
        ndone++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (d1 > 0 && c == d1 + 1) begin
        check("c_gap_busy", {31'd0, busy_c}, 32'd0);
        check("c_gap_line", {31'd0, ser_c}, 32'd1);
      end
      if (d1 > 0 && c == d1 + 2) begin
        check("c_restart_busy", {31'd0, busy_c}, 32'd1);
        check("c_restart_line", {31'd0, ser_c}, 32'd0);
      end
    end
    check("c_done_count", ndone, 2);
    check("c_first_done", d1, 80);
    check("c_done_spacing", d2 - d1, 81);

    repeat (20) @(negedge clk);
    check("sb_a_empty", exp_a.size(), 0);
    check("sb_b_empty", exp_b.size(), 0);
    check("sb_c_empty", exp_c.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
